pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter: CBITS, default 10, PWM counter width of the matching generator; internal counters and measurement outputs are CBITS+1 bits.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pwm_in  input  1  asynchronous PWM waveform from a generator.
REQ-005 duty  output  CBITS+1  high time of the last complete period, in clk cycles.
REQ-006 period  output  CBITS+1  rising-edge-to-rising-edge distance of the last complete period, in clk cycles.
REQ-007 valid  output  1  one-cycle strobe when duty/period/level update.
REQ-008 level  output  3  decoded duty level (inverse of the generator's 3-bit switch encoding).
REQ-009 stuck  output  1  no rising edge seen within timeout; input is static.
REQ-010 stuck_lvl  output  1  synchronized input level when stuck was raised.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer (s); a third flop (s_prev) SHALL provide edge detection; rise = s & ~s_prev.
REQ-012 FSM states SHALL be IDLE (waiting for the first rise) and MEASURE.
REQ-013 IDLE: on rise -> MEASURE, per_cnt <= 1, hi_cnt <= 1, no valid; otherwise counters hold.
REQ-014 MEASURE, non-rise cycle: per_cnt <= per_cnt+1; hi_cnt <= hi_cnt+s.
REQ-015 MEASURE, rise cycle: duty <= hi_cnt, period <= per_cnt, valid <= 1 next cycle, per_cnt <= 1, hi_cnt <= 1; stay in MEASURE.
REQ-016 Input high H and low L cycles (period P=H+L) SHALL publish duty=H, period=P exactly.
REQ-017 Latency: valid SHALL assert 4 clk cycles after the pwm_in rising edge that ends the period (2 sync, 1 edge, 1 register).
REQ-018 valid SHALL be high for exactly one cycle per published measurement and never in IDLE.
REQ-019 Timeout: in MEASURE or IDLE, if per_cnt reaches 2^(CBITS+1)-1 without a rise, go to IDLE, stuck <= 1, stuck_lvl <= s, counters hold; no valid.
REQ-020 In IDLE with no prior edge after reset, a separate timeout counter with the same limit SHALL raise stuck identically.
REQ-021 stuck SHALL clear on the next rise; the first period after a stuck clear SHALL be an arm-only rise (REQ-013), not published.
REQ-022 level on publish: duty >> (CBITS-4), saturated to 7 if the result exceeds 7.
REQ-023 level on stuck raise: 0 if stuck_lvl=0, 7 if stuck_lvl=1; duty/period hold.
REQ-024 A falling edge SHALL not alter counters beyond REQ-014; glitches shorter than 1 cycle are not required to be seen.
REQ-025 Counters SHALL never wrap; saturation at the timeout limit is the only overflow behaviour.

Reset
REQ-026 rst SHALL be synchronous and active-high; it takes priority over all other events in the same cycle.
REQ-027 On reset: state=IDLE, duty=0, period=0, valid=0, level=0, stuck=0, stuck_lvl=0, counters=0, synchronizer flops=0.
REQ-028 Reset mid-period SHALL discard the partial measurement; the next rise only arms.

Verification
REQ-029 CBITS=10, generator-style input high 192 / low 832, repeated -> from the second rise on, valid every 1024 cycles with duty=192, period=1024, level=3.
REQ-030 High 448 / low 576 -> duty=448, period=1024, level=7; high 64 / low 960 -> duty=64, level=1.
REQ-031 pwm_in held 0 after reset for 2100 cycles -> stuck=1 by cycle 2052, stuck_lvl=0, level=0, valid never asserted.
REQ-032 pwm_in held 1 mid-run past timeout -> stuck=1, stuck_lvl=1, level=7; a subsequent 192/832 waveform -> stuck clears on the first rise, first valid only after the second rise.
REQ-033 rst asserted for one cycle 500 cycles into a 192/832 stream -> all outputs 0 next cycle; the first post-reset valid follows the second rise after reset.
REQ-034 Check latency: valid rises exactly 4 cycles after the pwm_in rising edge that closes each period.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM measurement front end: synchronizes an external PWM waveform and publishes
// high time, period and a 3-bit level per complete period, with a stuck-input detector.
module pwm_capture #(
    parameter int CBITS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CBITS:0]   duty,
    output logic [CBITS:0]   period,
    output logic             valid,
    output logic [2:0]       level,
    output logic             stuck,
    output logic             stuck_lvl
);

    localparam int W = CBITS + 1;
    localparam logic [CBITS:0] LIMIT = '1;

    typedef enum logic {IDLE, MEASURE} state_t;

    function automatic logic [2:0] level_sat(input logic [CBITS:0] d);
        logic [CBITS:0] sh;
        sh = d >> (CBITS - 4);
        return (sh > W'(7)) ? 3'd7 : sh[2:0];
    endfunction

    state_t         state_q, state_d;
    logic           s1_q, s1_d, s_q, s_d, s_prev_q, s_prev_d, rise_q, rise_d;
    logic [CBITS:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d, to_cnt_q, to_cnt_d;
    logic [CBITS:0] duty_q, duty_d, period_q, period_d;
    logic           valid_q, valid_d, stuck_q, stuck_d, stuck_lvl_q, stuck_lvl_d;
    logic [2:0]     level_q, level_d;

    // s_prev_q is aligned with rise_q: both go high in the same cycle for a rising edge
    always_comb begin
        s1_d        = pwm_in;
        s_d         = s1_q;
        s_prev_d    = s_q;
        rise_d      = s_q & ~s_prev_q;
        state_d     = state_q;
        per_cnt_d   = per_cnt_q;
        hi_cnt_d    = hi_cnt_q;
        to_cnt_d    = to_cnt_q;
        duty_d      = duty_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        level_d     = level_q;
        stuck_d     = stuck_q;
        stuck_lvl_d = stuck_lvl_q;
        case (state_q)
            IDLE: begin
                if (rise_q) begin
                    state_d   = MEASURE;
                    per_cnt_d = W'(1);
                    hi_cnt_d  = W'(1);
                    to_cnt_d  = '0;
                    stuck_d   = 1'b0;
                end else if (!stuck_q) begin
                    if (to_cnt_q == LIMIT) begin
                        stuck_d     = 1'b1;
                        stuck_lvl_d = s_prev_q;
                        level_d     = s_prev_q ? 3'd7 : 3'd0;
                    end else begin
                        to_cnt_d = to_cnt_q + W'(1);
                    end
                end
            end
            MEASURE: begin
                if (rise_q) begin
                    duty_d    = hi_cnt_q;
                    period_d  = per_cnt_q;
                    valid_d   = 1'b1;
                    level_d   = level_sat(hi_cnt_q);
                    per_cnt_d = W'(1);
                    hi_cnt_d  = W'(1);
                end else if (per_cnt_q == LIMIT) begin
                    state_d     = IDLE;
                    stuck_d     = 1'b1;
                    stuck_lvl_d = s_prev_q;
                    level_d     = s_prev_q ? 3'd7 : 3'd0;
                end else begin
                    per_cnt_d = per_cnt_q + W'(1);
                    hi_cnt_d  = hi_cnt_q + W'(s_prev_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s_q         <= 1'b0;
            s_prev_q    <= 1'b0;
            rise_q      <= 1'b0;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            to_cnt_q    <= '0;
            duty_q      <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            level_q     <= 3'd0;
            stuck_q     <= 1'b0;
            stuck_lvl_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s_q         <= s_d;
            s_prev_q    <= s_prev_d;
            rise_q      <= rise_d;
            per_cnt_q   <= per_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            to_cnt_q    <= to_cnt_d;
            duty_q      <= duty_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            level_q     <= level_d;
            stuck_q     <= stuck_d;
            stuck_lvl_q <= stuck_lvl_d;
        end
    end

    assign duty      = duty_q;
    assign period    = period_q;
    assign valid     = valid_q;
    assign level     = level_q;
    assign stuck     = stuck_q;
    assign stuck_lvl = stuck_lvl_q;

endmodule
